// File: rtl/common_types_pkg.sv
// Shared AHB-Lite types: transfer type, transfer size and an alignment helper.
package common_types_pkg;

   typedef enum logic [1:0] {
      TransIdle   = 2'b00,
      TransBusy   = 2'b01,
      TransNonseq = 2'b10,
      TransSeq    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      SizeByte    = 2'b00,
      SizeHalf    = 2'b01,
      SizeWord    = 2'b10,
      SizeIllegal = 2'b11
   } size_t;

   // True when the address is not naturally aligned to the transfer size.
   function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lsb);
      logic result;
      result = 1'b0;
      if (size == SizeHalf && addr_lsb[0]) result = 1'b1;
      if (size == SizeWord && addr_lsb != 2'b00) result = 1'b1;
      return result;
   endfunction

endpackage

// File: rtl/ahb_bus_if.sv
// AHB-Lite single-master bus bundle with master and slave views.
interface ahb_bus_if;
   import common_types_pkg::*;

   logic [31:0] haddr;
   htrans_t     htrans;
   size_t       hsize;
   logic        hwrite;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport master (
      output haddr, htrans, hsize, hwrite, hwdata,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  haddr, htrans, hsize, hwrite, hwdata,
      output hrdata, hready, hresp
   );

endinterface

// File: rtl/ahb_master.sv
// Single-transfer AHB-Lite master: one request in, one NONSEQ transfer out, one response back.
// Optional macro AHB_MASTER_ALIGN_CHECK_EN rejects misaligned requests locally with an error.
module ahb_master
   import common_types_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   ahb_bus_if.master   ahb
);

   typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_t;

   localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_CYCLES);

   state_t      r_state;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [31:0] r_rsp_rdata;
   htrans_t     r_htrans;
   logic [31:0] r_haddr;
   size_t       r_hsize;
   logic        r_hwrite;
   logic [31:0] r_hwdata;
   logic [15:0] r_wait_cnt;

   logic        w_accept;
   logic        w_reject;
   logic [15:0] w_cnt_inc;

   assign w_accept  = req && r_req_ready;
   assign w_cnt_inc = r_wait_cnt + 16'd1;

   // Requests that must complete locally with an error and never touch the bus.
   always_comb begin
      w_reject = (size_t'(req_size) == SizeIllegal);
`ifdef AHB_MASTER_ALIGN_CHECK_EN
      if (is_misaligned(size_t'(req_size), req_addr[1:0])) w_reject = 1'b1;
`endif
   end

   // Transfer sequencer; every bus and response output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_htrans    <= TransIdle;
         r_haddr     <= '0;
         r_hsize     <= SizeByte;
         r_hwrite    <= 1'b0;
         r_hwdata    <= '0;
         r_wait_cnt  <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  if (w_reject) begin
                     r_state     <= StResp;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else begin
                     // Bus-facing registers only move for transfers that are issued.
                     r_state  <= StAddr;
                     r_htrans <= TransNonseq;
                     r_haddr  <= req_addr;
                     r_hsize  <= size_t'(req_size);
                     r_hwrite <= req_write;
                     r_hwdata <= req_wdata;
                  end
               end
            end
            StAddr: begin
               if (ahb.hready) begin
                  r_state    <= StData;
                  r_htrans   <= TransIdle;
                  r_wait_cnt <= '0;
               end
            end
            StData: begin
               if (ahb.hready) begin
                  r_state     <= StResp;
                  r_rsp_valid <= 1'b1;
                  if (ahb.hresp) begin
                     // Second cycle of the two-cycle error response.
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else if (!r_hwrite) begin
                     r_rsp_rdata <= ahb.hrdata;
                  end
               end else begin
                  r_wait_cnt <= w_cnt_inc;
                  if (w_cnt_inc == TimeoutCnt) begin
                     r_state     <= StResp;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end
               end
            end
            StResp: begin
               r_state     <= StIdle;
               r_req_ready <= 1'b1;
            end
            default: begin
               r_state     <= StIdle;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_err    = r_rsp_err;
   assign rsp_rdata  = r_rsp_rdata;
   assign ahb.htrans = r_htrans;
   assign ahb.haddr  = r_haddr;
   assign ahb.hsize  = r_hsize;
   assign ahb.hwrite = r_hwrite;
   assign ahb.hwdata = r_hwdata;

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: directed scenarios plus randomized transfers against a transaction-level model.
module tb_ahb_master;
   import common_types_pkg::*;

   localparam int unsigned TimeoutCycles = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] m_rdata;   // model of the rsp_rdata holding register

   ahb_bus_if bus ();

   ahb_master #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .ahb       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // A request completes locally when its size is illegal or, with the check enabled, misaligned.
   function automatic logic local_reject(input logic [1:0] sz, input logic [31:0] addr);
      logic bad;
      bad = (sz == 2'b11);
`ifdef AHB_MASTER_ALIGN_CHECK_EN
      if (sz == 2'b01 && addr[0] == 1'b1) bad = 1'b1;
      if (sz == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
`endif
      return bad;
   endfunction

   // One transfer: aw address-phase waits, w data-phase waits, optional two-cycle error response.
   task automatic run_txn(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int aw, input int w, input logic err);
      int zeros;
      int nd;
      logic exp_err;
      logic [31:0] exp_rd;
      @(negedge clk);
      check("idle_req_ready", req_ready, 1);
      req = 1'b1; req_write = wr; req_size = sz; req_addr = addr; req_wdata = wdata;
      bus.hready = 1'b1; bus.hresp = 1'b0;
      @(posedge clk); #1;
      req = 1'b0;
      if (local_reject(sz, addr)) begin
         @(negedge clk);
         check("rej_rsp_valid", rsp_valid, 1);
         check("rej_rsp_err", rsp_err, 1);
         check("rej_htrans", bus.htrans, TransIdle);
         check("rej_rdata", rsp_rdata, 0);
         m_rdata = 0;
         @(posedge clk); #1;
         @(negedge clk);
         check("rej_done_valid", rsp_valid, 0);
         check("rej_done_ready", req_ready, 1);
         check("rej_done_htrans", bus.htrans, TransIdle);
         return;
      end
      bus.hready = (aw == 0);
      @(negedge clk);
      check("addr_htrans", bus.htrans, TransNonseq);
      check("addr_haddr", bus.haddr, addr);
      check("addr_hsize", bus.hsize, {30'd0, sz});
      check("addr_hwrite", bus.hwrite, wr);
      check("addr_req_ready", req_ready, 0);
      for (int i = 0; i < aw; i++) begin
         @(posedge clk); #1;
         bus.hready = (i == aw - 1);
         @(negedge clk);
         check("addr_wait_htrans", bus.htrans, TransNonseq);
      end
      zeros = w + (err ? 1 : 0);
      nd = (zeros >= TimeoutCycles) ? TimeoutCycles : zeros + 1;
      for (int j = 0; j < nd; j++) begin
         @(posedge clk); #1;
         if (j < w) begin
            bus.hready = 1'b0; bus.hresp = 1'b0; bus.hrdata = $urandom;
         end else if (j == w) begin
            bus.hready = !err; bus.hresp = err; bus.hrdata = err ? $urandom : rdata;
         end else begin
            bus.hready = 1'b1; bus.hresp = 1'b1; bus.hrdata = $urandom;
         end
         @(negedge clk);
         check("data_htrans", bus.htrans, TransIdle);
         check("data_rsp_valid", rsp_valid, 0);
         if (wr) check("data_hwdata", bus.hwdata, wdata);
      end
      if (zeros >= TimeoutCycles) begin
         exp_err = 1'b1; exp_rd = 0;
      end else begin
         exp_err = err;
         exp_rd  = err ? 32'd0 : (wr ? m_rdata : rdata);
      end
      @(posedge clk); #1;
      bus.hready = 1'b1; bus.hresp = 1'b0;
      @(negedge clk);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_req_ready", req_ready, 0);
      m_rdata = exp_rd;
      @(posedge clk); #1;
      @(negedge clk);
      check("post_rsp_valid", rsp_valid, 0);
      check("post_rsp_err", rsp_err, 0);
      check("post_req_ready", req_ready, 1);
      check("post_rdata_hold", rsp_rdata, m_rdata);
   endtask

   // Start a read and assert reset asynchronously in ADDR (phase 0) or DATA (phase 1).
   task automatic reset_mid(input int phase);
      @(negedge clk);
      req = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0500;
      bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = 32'h1234_5678;
      @(posedge clk); #1;
      req = 1'b0;
      if (phase == 1) begin
         @(posedge clk); #1;
         bus.hready = 1'b0;
      end
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("rst_async_htrans", bus.htrans, TransIdle);
      check("rst_async_ready", req_ready, 1);
      check("rst_async_rdata", rsp_rdata, 0);
      check("rst_async_haddr", bus.haddr, 0);
      m_rdata = 0;
      bus.hready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rst_no_rsp", rsp_valid, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_addr = '0; req_wdata = '0;
      bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
      m_rdata = 0;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      check("reset_htrans", bus.htrans, TransIdle);
      check("reset_haddr", bus.haddr, 0);
      check("reset_hsize", bus.hsize, SizeByte);
      check("reset_hwrite", bus.hwrite, 0);
      check("reset_hwdata", bus.hwdata, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_err", rsp_err, 0);
      check("reset_rsp_rdata", rsp_rdata, 0);
      check("reset_req_ready", req_ready, 1);
      rst = 1'b0;

      // Zero-wait word read.
      run_txn(1'b0, 2'b10, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
      // Byte write with three data wait states.
      run_txn(1'b1, 2'b00, 32'h0000_0203, 32'h5500_0000, 32'h0, 0, 3, 1'b0);
      // Two-cycle slave error on a read.
      run_txn(1'b0, 2'b10, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b1);
      // Data phase stuck low: local timeout.
      run_txn(1'b0, 2'b10, 32'h0000_0304, 32'h0, 32'h0BAD_0BAD, 0, 8, 1'b0);
      // Illegal size, then a misaligned halfword.
      run_txn(1'b0, 2'b11, 32'h0000_0400, 32'h0, 32'h0, 0, 0, 1'b0);
      run_txn(1'b0, 2'b01, 32'h0000_0401, 32'h0, 32'hA5A5_1234, 0, 0, 1'b0);
      // Address-phase wait state.
      run_txn(1'b1, 2'b01, 32'h0000_0602, 32'h1357_0000, 32'h0, 2, 1, 1'b0);

      reset_mid(1);
      reset_mid(0);

      for (int n = 0; n < 40; n++) begin
         run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                 $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 5)),
                 ($urandom_range(0, 3) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb_master.md
AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 256, data-phase wait cycles before local abort; legal range 1..65535.
REQ-002 Port: clk  in  1  single clock, all state on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: req  in  1  core requests a transfer.
REQ-005 Port: req_ready  out  1  high only in IDLE; a request is accepted on a rising edge where req && req_ready.
REQ-006 Port: req_write  in  1  1=write, 0=read.
REQ-007 Port: req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 Port: req_addr  in  32  byte address.
REQ-009 Port: req_wdata  in  32  write data, lane-aligned by the core.
REQ-010 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-011 Port: rsp_err  out  1  valid with rsp_valid; 1=error or timeout.
REQ-012 Port: rsp_rdata  out  32  read data, valid with rsp_valid on a read without error.
REQ-013 Port: ahb_bus_if  master modport  --  drives haddr, htrans, hsize, hwrite, hwdata; samples hrdata, hready, hresp.

Function
REQ-014 States: IDLE, ADDR, DATA, RESP.
REQ-015 On accept, register write, size, addr, wdata; IDLE->ADDR, except size 11, which goes IDLE->RESP with error and no bus activity.
REQ-016 ADDR: htrans=NONSEQ, haddr/hsize/hwrite from registered request; hold until hready=1, then ->DATA.
REQ-017 DATA: htrans=IDLE; hwdata=registered wdata, held stable through all wait cycles.
REQ-018 DATA with hready=1 and hresp=0: capture hrdata (reads), ->RESP with rsp_err=0.
REQ-019 DATA with hresp=1: ->RESP with rsp_err=1 on the cycle hready=1 (second cycle of the two-cycle error response); rsp_rdata=0.
REQ-020 Timeout: 16-bit counter clears on entering DATA, increments each DATA cycle with hready=0; on reaching TIMEOUT_CYCLES ->RESP, rsp_err=1.
REQ-021 RESP: rsp_valid=1 for exactly one cycle, then ->IDLE; no request is accepted in RESP.
REQ-022 Zero-wait latency: accept at edge N, ADDR cycle N+1, DATA cycle N+2, rsp_valid in cycle N+3; each wait state adds one cycle.
REQ-023 Outside ADDR, htrans=IDLE, and haddr/hsize/hwrite hold last values.
REQ-024 When not in RESP, rsp_valid=0 and rsp_err=0.
REQ-025 rsp_rdata holds its last value until the next response.

Reset
REQ-026 rst asserted at any time, including mid-transfer, forces IDLE asynchronously.
REQ-027 Reset values: htrans=IDLE, haddr=0, hsize=00, hwrite=0, hwdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0, req_ready=1.
REQ-028 A transfer interrupted by reset produces no response.

Configuration
REQ-029 Macro AHB_MASTER_ALIGN_CHECK_EN defined: a misaligned request (halfword with addr[0]=1, or word with addr[1:0]!=00) goes IDLE->RESP with rsp_err=1 and no bus activity.
REQ-030 Macro undefined: misaligned requests are issued unchanged on the bus.

Structure
REQ-031 htrans_t (IDLE, BUSY, NONSEQ, SEQ) and a size enum live in common_types_pkg; the state enum is local.
REQ-032 Single module, no sub-modules; the timeout counter is inline.

Verification
REQ-033 Word read 0x100, zero-wait slave returns 0xDEADBEEF -> NONSEQ in cycle N+1; rsp_valid=1, rsp_err=0, rsp_rdata=0xDEADBEEF in cycle N+3.
REQ-034 Byte write 0x203 data 0x55000000, slave inserts 3 wait states -> hsize=00, hwdata stable for 4 DATA cycles, rsp_valid in cycle N+6.
REQ-035 Slave two-cycle error response on read 0x300 -> rsp_err=1, rsp_rdata=0, back to IDLE next cycle.
REQ-036 TIMEOUT_CYCLES=4, hready held low in DATA -> rsp_err=1 after 4 wait cycles.
REQ-037 req_size=11 -> rsp_valid and rsp_err one cycle after accept, htrans never NONSEQ; halfword at 0x401 errs the same way only with AHB_MASTER_ALIGN_CHECK_EN defined.
REQ-038 rst pulsed in DATA -> htrans=IDLE and req_ready=1 immediately; no rsp_valid.
